// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for a MIPS-style pipeline.
// An accepted MULT/DIV holds busy for a fixed countdown, then writes HI/LO at once.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          st_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      op_q;
  logic [31:0]     a_q, b_q;
  logic [31:0]     hi_q, lo_q;

  logic            start_md;
  logic signed [63:0] sa, sb, prod_s;
  logic [63:0]     prod_u;
  logic            a_neg, b_neg;
  logic [31:0]     abs_a, abs_b, divisor, q_u, r_u;
  logic [31:0]     res_hi, res_lo;
  logic            res_wr;

  assign start_md = start && (op == OpMult || op == OpMultu || op == OpDiv || op == OpDivu);
  // Reset gates the countdown term so an aborted op never shows busy.
  assign busy = start_md || (!reset && cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Signed division goes through magnitudes so INT_MIN / -1 wraps cleanly.
  always_comb begin
    sa      = {{32{a_q[31]}}, a_q};
    sb      = {{32{b_q[31]}}, b_q};
    prod_s  = sa * sb;
    prod_u  = {32'h0, a_q} * {32'h0, b_q};
    a_neg   = (op_q == OpDiv) && a_q[31];
    b_neg   = (op_q == OpDiv) && b_q[31];
    abs_a   = a_neg ? (32'd0 - a_q) : a_q;
    abs_b   = b_neg ? (32'd0 - b_q) : b_q;
    divisor = (abs_b == 32'd0) ? 32'd1 : abs_b;
    q_u     = abs_a / divisor;
    r_u     = abs_a % divisor;
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    res_wr  = 1'b0;
    case (op_q)
      OpMult: begin
        {res_hi, res_lo} = prod_s;
        res_wr           = 1'b1;
      end
      OpMultu: begin
        {res_hi, res_lo} = prod_u;
        res_wr           = 1'b1;
      end
      OpDiv, OpDivu: begin
        res_lo = (a_neg ^ b_neg) ? (32'd0 - q_u) : q_u;
        res_hi = a_neg ? (32'd0 - r_u) : r_u;
        res_wr = (b_q != 32'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= StIdle;
      cnt_q <= '0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      case (st_q)
        StIdle: begin
          if (start) begin
            case (op)
              OpMult, OpMultu, OpDiv, OpDivu: begin
                st_q  <= StRun;
                cnt_q <= (op == OpMult || op == OpMultu) ? CntW'(MULT_CYCLES)
                                                         : CntW'(DIV_CYCLES);
                op_q  <= op;
                a_q   <= src0;
                b_q   <= src1;
              end
              OpMthi:  hi_q <= src0;
              OpMtlo:  lo_q <= src0;
              default: ;
            endcase
          end
        end
        StRun: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            st_q <= StIdle;
            if (res_wr) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

endmodule
